cola_fifo_nivel: RTL and testbench
==================================

Name: cola_fifo_nivel

Overview:
Parametrised successor to the team's single-clock FIFO queue, with all 2**W entries usable. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a registered read-data path with a valid strobe, and sticky overflow/underflow flags with explicit clear. Sits between UART/serial front-ends and the processing datapath, where producers need early back-pressure.

Parameters:
B, 8, data word width in bits
W, 4, address bits; depth = 2**W entries, all usable
AF_DEF, 2**W-2, reset value of almost-full threshold
AE_DEF, 1, reset value of almost-empty threshold

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wr  input  1  push request
in  input  B  push data
rd  input  1  pop request
data  output  B  read data
data_valid  output  1  data holds a freshly popped word
full  output  1  count == 2**W
empty  output  1  count == 0
almost_full  output  1  count >= af_thr
almost_empty  output  1  count <= ae_thr
count  output  W+1  current occupancy, 0..2**W
af_thr  input  W+1  almost-full threshold; sampled only when thr_ld=1
ae_thr  input  W+1  almost-empty threshold; sampled only when thr_ld=1
thr_ld  input  1  load both thresholds into internal registers
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
clr_err  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data=0, data_valid=0, overflow=0, underflow=0, thresholds=AF_DEF/AE_DEF. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words; first push after release lands at address 0.
- wr_en = wr & ~full; rd_en = rd & ~empty. Both are evaluated on registered flags at the current edge.
- Push: mem[w_ptr] <= in; w_ptr +1 modulo 2**W; count +1.
- Pop: data <= mem[r_ptr]; data_valid=1 for exactly the following cycle; r_ptr +1 modulo 2**W; count -1. Latency is 1 cycle. data holds its value when there is no pop; data_valid=0 otherwise.
- Push and pop in the same cycle, 0<count<2**W: both execute, count unchanged, flags unchanged.
- wr and rd while empty: only the push executes (count=1). underflow is set and no data_valid pulse is produced.
- wr and rd while full: only the pop executes (count=2**W-1). overflow is set.
- Pointer wrap: free-running W-bit pointers. full and empty are derived from the W+1-bit count, never from pointer equality alone.
- Status flags: full, empty, almost_full and almost_empty are registered, updated on the same edge as count, and consistent with count at all times.
- Thresholds: thr_ld=1 loads af_thr and ae_thr at the edge. Flags reflect the new thresholds from the next cycle.
- Error flags: overflow and underflow are set on the edge of the offending request and stay set until clr_err=1. If set and clear occur in the same cycle, set wins.
- The state machine in the count logic is {idle, push, pop, push_pop}, selected by {wr_en, rd_en}. It has no illegal states.

Optional Feature:
COLA_FIFO_FWFT_EN. When defined, the FIFO runs first-word-fall-through: data = mem[r_ptr] combinationally whenever empty=0, and data_valid = ~empty. rd acknowledges and discards the head word, so the next word or an empty indication appears on the following cycle. When undefined, the registered 1-cycle-latency read path described above applies.

Test Plan:
- Reset, then push 0x11,0x22,0x33 and pop 3 -> data 0x11,0x22,0x33 each one cycle after its rd; data_valid pulses 3×; count returns to 0 and empty=1.
- Push 16 words (W=4) -> full=1 and count=16 on the 16th edge; a 17th wr sets overflow=1 with count still 16; the word 0x00..0x0F order is preserved on drain.
- With count=16, assert wr=1, rd=1 with in=0xAA -> pop only, count=15, overflow=1; clr_err clears overflow the next cycle.
- Load af_thr=4, ae_thr=2 and push 5 -> almost_empty drops at count=3 and almost_full rises at count=4.
- Fill to 8, then push and pop together for 20 cycles -> count stays at 8 with data in order across pointer wrap; drop reset mid-stream -> all outputs at reset values immediately, asynchronously.
- With COLA_FIFO_FWFT_EN defined, push 0x5A -> data=0x5A and data_valid=1 the cycle after the push with no rd; rd -> empty=1 the next cycle.

Source files
------------

// File: rtl/cola_fifo_nivel.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds,
// and sticky overflow/underflow flags. Define COLA_FIFO_FWFT_EN for first-word-fall-through reads.
module cola_fifo_nivel #(
  parameter int unsigned B      = 8,
  parameter int unsigned W      = 4,
  parameter int unsigned AF_DEF = 2**W - 2,
  parameter int unsigned AE_DEF = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] in,
  input  logic         rd,
  output logic [B-1:0] data,
  output logic         data_valid,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  input  logic [W:0]   af_thr,
  input  logic [W:0]   ae_thr,
  input  logic         thr_ld,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam int unsigned DEPTH = 2**W;
  localparam int unsigned CW    = W + 1;

  typedef enum logic [1:0] {
    OP_IDLE     = 2'b00,
    OP_POP      = 2'b01,
    OP_PUSH     = 2'b10,
    OP_PUSH_POP = 2'b11
  } op_t;

  logic [B-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_wptr;
  logic [W-1:0]  r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic          r_unf;
  logic [CW-1:0] r_af_thr;
  logic [CW-1:0] r_ae_thr;

  logic          w_wr_en;
  logic          w_rd_en;
  op_t           w_op;
  logic [CW-1:0] w_count_nxt;

  // Enables are qualified by the registered flags of the current cycle
  assign w_wr_en = wr & ~r_full;
  assign w_rd_en = rd & ~r_empty;

  // Operation decode and next occupancy
  always_comb begin
    w_op        = op_t'({w_wr_en, w_rd_en});
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH:     w_count_nxt = r_count + CW'(1);
      OP_POP:      w_count_nxt = r_count - CW'(1);
      OP_PUSH_POP: w_count_nxt = r_count;
      default:     w_count_nxt = r_count;
    endcase
  end

  // Occupancy, pointers and status flags; flags follow the next count so they never lag it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_af_thr <= CW'(AF_DEF);
      r_ae_thr <= CW'(AE_DEF);
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + W'(1);
      if (w_rd_en) r_rptr <= r_rptr + W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= r_af_thr);
      r_ae    <= (w_count_nxt <= r_ae_thr);
      if (thr_ld) begin
        r_af_thr <= af_thr;
        r_ae_thr <= ae_thr;
      end
    end
  end

  // Sticky error flags; a new offence in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr && r_full)       r_ovf <= 1'b1;
      else if (clr_err)       r_ovf <= 1'b0;
      if (rd && r_empty)      r_unf <= 1'b1;
      else if (clr_err)       r_unf <= 1'b0;
    end
  end

  // Storage array is intentionally left unreset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= in;
  end

`ifdef COLA_FIFO_FWFT_EN
  assign data       = r_empty ? '0 : r_mem[r_rptr];
  assign data_valid = ~r_empty;
`else
  logic [B-1:0] r_data;
  logic         r_dv;

  // Registered read port: word appears one cycle after the accepted pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_dv   <= 1'b0;
    end else begin
      if (w_rd_en) r_data <= r_mem[r_rptr];
      r_dv <= w_rd_en;
    end
  end

  assign data       = r_data;
  assign data_valid = r_dv;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_cola_fifo_nivel.sv
// Directed self-checking bench for cola_fifo_nivel (B=8, W=4).
module tb_cola_fifo_nivel;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] in;
  logic       rd;
  logic [7:0] data;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic [4:0] af_thr;
  logic [4:0] ae_thr;
  logic       thr_ld;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_total;
  int n_bad;

  cola_fifo_nivel #(.B(8), .W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .in           (in),
    .rd           (rd),
    .data         (data),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .thr_ld       (thr_ld),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    in      = 8'h00;
    af_thr  = 5'd0;
    ae_thr  = 5'd0;
    thr_ld  = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_af",    32'(almost_full), 32'd0);
    chk("rst_data",  32'(data), 32'd0);
    chk("rst_dv",    32'(data_valid), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_unf",   32'(underflow), 32'd0);

`ifdef COLA_FIFO_FWFT_EN
    wr = 1'b1; in = 8'h5A; step();
    wr = 1'b0;
    chk("fw_data1", 32'(data), 32'h5A);
    chk("fw_dv1",   32'(data_valid), 32'd1);
    chk("fw_cnt1",  32'(count), 32'd1);
    step();
    chk("fw_hold",  32'(data), 32'h5A);
    wr = 1'b1; in = 8'h6B; step();
    wr = 1'b0;
    chk("fw_head",  32'(data), 32'h5A);
    rd = 1'b1; step();
    chk("fw_data2", 32'(data), 32'h6B);
    chk("fw_cnt2",  32'(count), 32'd1);
    step();
    rd = 1'b0;
    chk("fw_empty", 32'(empty), 32'd1);
    chk("fw_dv0",   32'(data_valid), 32'd0);
    chk("fw_cnt0",  32'(count), 32'd0);
`else
    // Basic push/pop with one-cycle read latency
    wr = 1'b1;
    in = 8'h11; step();
    in = 8'h22; step();
    in = 8'h33; step();
    wr = 1'b0;
    chk("t1_cnt3", 32'(count), 32'd3);
    rd = 1'b1;
    step(); chk("t1_d0", 32'(data), 32'h11); chk("t1_v0", 32'(data_valid), 32'd1);
    step(); chk("t1_d1", 32'(data), 32'h22); chk("t1_v1", 32'(data_valid), 32'd1);
    step(); chk("t1_d2", 32'(data), 32'h33); chk("t1_v2", 32'(data_valid), 32'd1);
    chk("t1_cnt0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    rd = 1'b0;
    step();
    chk("t1_vlow", 32'(data_valid), 32'd0);
    chk("t1_hold", 32'(data), 32'h33);

    // Fill to full, then overflow
    wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in = 8'(i);
      step();
      if (i == 14) begin
        chk("t2_cnt15", 32'(count), 32'd15);
        chk("t2_nfull", 32'(full), 32'd0);
      end
    end
    chk("t2_cnt16", 32'(count), 32'd16);
    chk("t2_full",  32'(full), 32'd1);
    chk("t2_af",    32'(almost_full), 32'd1);
    in = 8'hEE; step();
    chk("t2_ovf",   32'(overflow), 32'd1);
    chk("t2_cnt",   32'(count), 32'd16);

    // Push+pop while full: only the pop executes
    rd = 1'b1; in = 8'hAA; step();
    chk("t3_cnt15", 32'(count), 32'd15);
    chk("t3_ovf",   32'(overflow), 32'd1);
    chk("t3_data",  32'(data), 32'h00);
    chk("t3_dv",    32'(data_valid), 32'd1);
    chk("t3_nfull", 32'(full), 32'd0);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("t3_clr",   32'(overflow), 32'd0);
    rd = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t3_drain", 32'(data), 32'(i));
    end
    rd = 1'b0;
    chk("t3_empty", 32'(empty), 32'd1);

    // Push+pop while empty: push only, underflow set, no valid pulse
    wr = 1'b1; rd = 1'b1; in = 8'h77; step();
    wr = 1'b0; rd = 1'b0;
    chk("t3_ecnt", 32'(count), 32'd1);
    chk("t3_unf",  32'(underflow), 32'd1);
    chk("t3_edv",  32'(data_valid), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t3_uclr", 32'(underflow), 32'd0);
    rd = 1'b1; step(); rd = 1'b0;
    chk("t3_d77",  32'(data), 32'h77);

    // Programmable thresholds
    af_thr = 5'd4; ae_thr = 5'd2; thr_ld = 1'b1; step(); thr_ld = 1'b0;
    wr = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in = 8'(k);
      step();
      chk("t4_ae", 32'(almost_empty), (k <= 2) ? 32'd1 : 32'd0);
      chk("t4_af", 32'(almost_full),  (k >= 4) ? 32'd1 : 32'd0);
    end
    wr = 1'b0; rd = 1'b1;
    repeat (5) step();
    rd = 1'b0;
    chk("t4_cnt0", 32'(count), 32'd0);

    // Steady state at 8 with simultaneous push/pop across pointer wrap
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 8'(8'h80 + i);
      step();
    end
    rd = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in = 8'(8'h90 + j);
      step();
      chk("t5_data", 32'(data), (j < 8) ? 32'(8'h80 + j) : 32'(8'h90 + j - 8));
      chk("t5_cnt",  32'(count), 32'd8);
    end
    wr = 1'b0; rd = 1'b0;

    // Asynchronous reset mid-stream
    #2 reset = 1'b0;
    #1;
    chk("t5_rcnt",  32'(count), 32'd0);
    chk("t5_remp",  32'(empty), 32'd1);
    chk("t5_rdata", 32'(data), 32'd0);
    chk("t5_rdv",   32'(data_valid), 32'd0);
    chk("t5_rae",   32'(almost_empty), 32'd1);
    chk("t5_raf",   32'(almost_full), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    wr = 1'b1; in = 8'h3C; step(); wr = 1'b0;
    rd = 1'b1; step(); rd = 1'b0;
    chk("t5_post", 32'(data), 32'h3C);
    chk("t5_pcnt", 32'(count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
